pwl_segment_search: RTL

- Sequential successor to the fixed breakpoint lookup used by the piecewise-linear tanh/sigmoid approximators in the LSTM datapath.
- Holds NBANK runtime-loadable breakpoint tables (bank 0 tanh, bank 1 sigmoid by convention).
- For an unsigned input magnitude x, binary-searches the selected bank for the containing segment index j, then returns j and the two segment endpoints half_j and half_j_1.
- Sits between the input-magnitude/sign stage and the slope/intercept multiply stage. Valid/ready on both sides.

---
 rtl/pwl_pkg.sv | 20 ++
 rtl/pwl_bp_table.sv | 52 +++++
 rtl/pwl_segment_search.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pwl_pkg.sv
// Shared types and defaults for the piecewise-linear segment search.
// Bank indices follow the tanh/sigmoid split used by the LSTM datapath.
package pwl_pkg;

   localparam int PWL_XDW   = 24;
   localparam int PWL_ML    = 275;
   localparam int PWL_MW    = 9;
   localparam int PWL_NBANK = 2;
   localparam int PWL_BW    = 1;

   localparam int BANK_TANH    = 0;
   localparam int BANK_SIGMOID = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_DONE
   } pwl_state_t;

endpackage

// File: rtl/pwl_bp_table.sv
// Banked breakpoint register file: one write port, three async read ports.
// Out-of-range writes are dropped and out-of-range reads return zero.
module pwl_bp_table
   import pwl_pkg::*;
#(
   parameter int XDW   = PWL_XDW,
   parameter int ML    = PWL_ML,
   parameter int MW    = PWL_MW,
   parameter int NBANK = PWL_NBANK,
   parameter int BW    = PWL_BW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [BW-1:0]  wbank,
   input  logic [MW-1:0]  waddr,
   input  logic [XDW-1:0] wdata,
   input  logic [BW-1:0]  rbank,
   input  logic [MW-1:0]  ra_mid,
   input  logic [MW-1:0]  ra_lo,
   input  logic [MW-1:0]  ra_lo1,
   output logic [XDW-1:0] rd_mid,
   output logic [XDW-1:0] rd_lo,
   output logic [XDW-1:0] rd_lo1
);

   localparam int NE = ML + 2;

   logic [XDW-1:0] mem [NBANK][NE];
   logic           wok;
   logic           bok;

   assign wok = we && (int'(wbank) < NBANK) && (int'(waddr) < NE);
   assign bok = int'(rbank) < NBANK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NBANK; b++) begin
            for (int e = 0; e < NE; e++) begin
               mem[b][e] <= '0;
            end
         end
      end else if (wok) begin
         mem[wbank][waddr] <= wdata;
      end
   end

   assign rd_mid = (bok && int'(ra_mid) < NE) ? mem[rbank][ra_mid] : '0;
   assign rd_lo  = (bok && int'(ra_lo)  < NE) ? mem[rbank][ra_lo]  : '0;
   assign rd_lo1 = (bok && int'(ra_lo1) < NE) ? mem[rbank][ra_lo1] : '0;

endmodule

// File: rtl/pwl_segment_search.sv
// Fixed-latency binary search of a runtime-loaded breakpoint bank.
// Returns the containing segment index and both segment endpoints.
module pwl_segment_search
   import pwl_pkg::*;
#(
   parameter int XDW   = PWL_XDW,
   parameter int ML    = PWL_ML,
   parameter int MW    = PWL_MW,
   parameter int NBANK = PWL_NBANK,
   parameter int BW    = PWL_BW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [XDW-1:0] in_x,
   input  logic [BW-1:0]  in_bank,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [MW-1:0]  j_out,
   output logic [XDW-1:0] half_j,
   output logic [XDW-1:0] half_j_1,
   output logic           sat,
   input  logic           cfg_we,
   input  logic [BW-1:0]  cfg_bank,
   input  logic [MW-1:0]  cfg_addr,
   input  logic [XDW-1:0] cfg_data,
   output logic           cfg_ready
);

   localparam int IW = $clog2(MW + 1);
   localparam logic [MW-1:0] LAST = MW'(ML + 1);
   localparam logic [MW-1:0] JMAX = MW'(ML);

   pwl_state_t     state;
   logic [XDW-1:0] x_q;
   logic [BW-1:0]  bank_q;
   logic [MW-1:0]  lo;
   logic [MW-1:0]  hi;
   logic [IW-1:0]  iter;
   logic           sat_q;

   logic [MW:0]    sum;
   logic [MW-1:0]  mid;
   logic [MW-1:0]  jsel;
   logic [MW-1:0]  jsel1;
   logic [MW-1:0]  ra_mid;
   logic [BW-1:0]  rbank;
   logic [XDW-1:0] t_mid;
   logic [XDW-1:0] t_lo;
   logic [XDW-1:0] t_lo1;
   logic [XDW-1:0] t_last;
   logic           accept;
   logic           wr;
   logic           last_fwd;

   assign in_ready  = (state == ST_IDLE);
   assign cfg_ready = (state == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign wr        = cfg_we && cfg_ready;

   assign sum   = {1'b0, lo} + {1'b0, hi};
   assign mid   = sum[MW:1];
   assign jsel  = sat_q ? JMAX : lo;
   assign jsel1 = jsel + 1'b1;

   // In IDLE the mid port looks up the last breakpoint for the sat test.
   assign rbank  = in_ready ? in_bank : bank_q;
   assign ra_mid = in_ready ? LAST : mid;

   // A same-cycle write to the last breakpoint must be seen by sat.
   assign last_fwd = wr && (cfg_bank == in_bank) && (cfg_addr == LAST);
   assign t_last   = last_fwd ? cfg_data : t_mid;

   pwl_bp_table #(
      .XDW   (XDW),
      .ML    (ML),
      .MW    (MW),
      .NBANK (NBANK),
      .BW    (BW)
   ) u_table (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wr),
      .wbank  (cfg_bank),
      .waddr  (cfg_addr),
      .wdata  (cfg_data),
      .rbank  (rbank),
      .ra_mid (ra_mid),
      .ra_lo  (jsel),
      .ra_lo1 (jsel1),
      .rd_mid (t_mid),
      .rd_lo  (t_lo),
      .rd_lo1 (t_lo1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         x_q       <= '0;
         bank_q    <= '0;
         lo        <= '0;
         hi        <= '0;
         iter      <= '0;
         sat_q     <= 1'b0;
         out_valid <= 1'b0;
         j_out     <= '0;
         half_j    <= '0;
         half_j_1  <= '0;
         sat       <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  x_q    <= in_x;
                  bank_q <= in_bank;
                  lo     <= MW'(1);
                  hi     <= LAST;
                  iter   <= '0;
                  sat_q  <= (in_x >= t_last);
                  state  <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (iter == IW'(MW)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  j_out     <= jsel;
                  half_j    <= t_lo;
                  half_j_1  <= t_lo1;
                  sat       <= sat_q;
               end else begin
                  iter <= iter + 1'b1;
                  if (hi - lo > MW'(1)) begin
                     if (t_mid <= x_q) lo <= mid;
                     else hi <= mid;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
